// File: rtl/layer3_pkg.sv
// Shared types and constants for the layer-3 final-reduction accumulator.
package layer3_pkg;

  localparam int unsigned PROD_W = 32;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned OP_W   = 19;
  localparam int unsigned ERR_W  = 16;
  localparam int unsigned IDX_W  = 2;

  // Alignment of each layer-2 sum (a, b, c, d) within the product
  localparam int unsigned OP_SHIFT0 = 0;
  localparam int unsigned OP_SHIFT1 = 4;
  localparam int unsigned OP_SHIFT2 = 8;
  localparam int unsigned OP_SHIFT3 = 12;

  // Alignment of each error vector (ei, ej, ek, el) within the product
  localparam int unsigned ERR_SHIFT0 = 2;
  localparam int unsigned ERR_SHIFT1 = 6;
  localparam int unsigned ERR_SHIFT2 = 10;
  localparam int unsigned ERR_SHIFT3 = 14;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUM  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Zero-extend a partial sum to product width and place it at its weight
  function automatic logic [PROD_W-1:0] align_op(input logic [OP_W-1:0] v,
                                                 input int unsigned sh);
    return PROD_W'(v) << sh;
  endfunction

  // Zero-extend an error vector to product width and place it at its weight
  function automatic logic [PROD_W-1:0] align_err(input logic [ERR_W-1:0] v,
                                                  input int unsigned sh);
    return PROD_W'(v) << sh;
  endfunction

endpackage

// File: rtl/layer3_accumulator_if.sv
// Operand/result handshake bundle between the compressor array, the
// accumulator and the product consumer.
interface layer3_accumulator_if;
  import layer3_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic              rec_en;
  logic [19:1]       a;
  logic [23:5]       b;
  logic [27:9]       c;
  logic [31:13]      d;
  logic [18:3]       ei;
  logic [22:7]       ej;
  logic [26:11]      ek;
  logic [30:15]      el;
  logic              out_valid;
  logic              out_ready;
  logic [32:1]       product;
  logic              err_flag;
  logic [CNT_W-1:0]  err_count;

  modport master (
    output in_valid, rec_en, a, b, c, d, ei, ej, ek, el, out_ready,
    input  in_ready, out_valid, product, err_flag, err_count
  );

  modport slave (
    input  in_valid, rec_en, a, b, c, d, ei, ej, ek, el, out_ready,
    output in_ready, out_valid, product, err_flag, err_count
  );

endinterface

// File: rtl/layer3_accumulator.sv
// Layer-3 sequential reduction: captures four partial sums and four error
// vectors, adds them one per cycle into a 32-bit product, optionally adds the
// error terms back, and counts products that carried a non-zero error.
module layer3_accumulator
  import layer3_pkg::*;
(
  input logic                clk,
  input logic                rst,
  layer3_accumulator_if.slave bus
);

  state_t              state;
  state_t              state_next;
  logic [IDX_W-1:0]    idx;
  logic [PROD_W-1:0]   acc;
  logic [PROD_W-1:0]   term_c;
  logic [PROD_W-1:0]   acc_sum_c;
  logic                last_add_c;

  logic [OP_W-1:0]     cap_a;
  logic [OP_W-1:0]     cap_b;
  logic [OP_W-1:0]     cap_c;
  logic [OP_W-1:0]     cap_d;
  logic [ERR_W-1:0]    cap_ei;
  logic [ERR_W-1:0]    cap_ej;
  logic [ERR_W-1:0]    cap_ek;
  logic [ERR_W-1:0]    cap_el;
  logic                cap_rec;

  logic [PROD_W-1:0]   product_q;
  logic                err_flag_q;
  logic [CNT_W-1:0]    err_count_q;
  logic                in_ready_q;
  logic                out_valid_q;

  assign last_add_c = (idx == IDX_W'(3));
  assign acc_sum_c  = acc + term_c;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state decode
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (bus.in_valid) state_next = SUM;
      SUM:  if (last_add_c)   state_next = cap_rec ? FIX : DONE;
      FIX:  if (last_add_c)   state_next = DONE;
      DONE: if (bus.out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operand-alignment mux: pick this cycle's aligned addend by phase and idx
  always_comb begin
    term_c = '0;
    if (state == SUM) begin
      case (idx)
        2'd0: term_c = align_op(cap_a, OP_SHIFT0);
        2'd1: term_c = align_op(cap_b, OP_SHIFT1);
        2'd2: term_c = align_op(cap_c, OP_SHIFT2);
        2'd3: term_c = align_op(cap_d, OP_SHIFT3);
      endcase
    end else if (state == FIX) begin
      case (idx)
        2'd0: term_c = align_err(cap_ei, ERR_SHIFT0);
        2'd1: term_c = align_err(cap_ej, ERR_SHIFT1);
        2'd2: term_c = align_err(cap_ek, ERR_SHIFT2);
        2'd3: term_c = align_err(cap_el, ERR_SHIFT3);
      endcase
    end
  end

  // Handshake flags registered from the upcoming state
  always_ff @(posedge clk) begin
    if (rst) begin
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      in_ready_q  <= (state_next == IDLE);
      out_valid_q <= (state_next == DONE);
    end
  end

  // Capture, accumulate, publish the product and count errored results
  always_ff @(posedge clk) begin
    if (rst) begin
      cap_a       <= '0;
      cap_b       <= '0;
      cap_c       <= '0;
      cap_d       <= '0;
      cap_ei      <= '0;
      cap_ej      <= '0;
      cap_ek      <= '0;
      cap_el      <= '0;
      cap_rec     <= 1'b0;
      acc         <= '0;
      idx         <= '0;
      product_q   <= '0;
      err_flag_q  <= 1'b0;
      err_count_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            cap_a      <= bus.a;
            cap_b      <= bus.b;
            cap_c      <= bus.c;
            cap_d      <= bus.d;
            cap_ei     <= bus.ei;
            cap_ej     <= bus.ej;
            cap_ek     <= bus.ek;
            cap_el     <= bus.el;
            cap_rec    <= bus.rec_en;
            err_flag_q <= (|bus.ei) | (|bus.ej) | (|bus.ek) | (|bus.el);
            acc        <= '0;
            idx        <= '0;
          end
        end
        SUM, FIX: begin
          acc <= acc_sum_c;
          idx <= idx + IDX_W'(1);
          if (state_next == DONE) product_q <= acc_sum_c;
        end
        DONE: begin
          if (bus.out_ready && err_flag_q && (err_count_q != {CNT_W{1'b1}}))
            err_count_q <= err_count_q + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.product   = product_q;
  assign bus.err_flag  = err_flag_q;
  assign bus.err_count = err_count_q;

endmodule

// File: tb/tb_layer3_accumulator.sv
// Self-checking bench for layer3_accumulator: directed scenarios plus
// randomized transactions compared against an arithmetic reference model.
module tb_layer3_accumulator;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  layer3_accumulator_if bus ();

  layer3_accumulator dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  logic [18:0] op_a, op_b, op_c, op_d;
  logic [15:0] op_ei, op_ej, op_ek, op_el;
  logic        op_rec;
  logic        pend_err;
  logic [15:0] exp_cnt;

  // Reference: weighted sum of the vectors, wrapped to 32 bits
  function automatic logic [31:0] model_product();
    longint unsigned s;
    s = longint'(op_a) + longint'(op_b) * 16 + longint'(op_c) * 256 +
        longint'(op_d) * 4096;
    if (op_rec)
      s = s + longint'(op_ei) * 4 + longint'(op_ej) * 64 +
          longint'(op_ek) * 1024 + longint'(op_el) * 16384;
    return s[31:0];
  endfunction

  function automatic logic model_err();
    return (op_ei != 0) || (op_ej != 0) || (op_ek != 0) || (op_el != 0);
  endfunction

  task automatic set_ops(input logic [18:0] a, b, c, d,
                         input logic [15:0] ei, ej, ek, el, input logic rec);
    op_a = a; op_b = b; op_c = c; op_d = d;
    op_ei = ei; op_ej = ej; op_ek = ek; op_el = el; op_rec = rec;
  endtask

  task automatic rand_ops(input bit with_err);
    op_a = 19'($urandom); op_b = 19'($urandom);
    op_c = 19'($urandom); op_d = 19'($urandom);
    op_ei = with_err ? 16'($urandom) : 16'd0;
    op_ej = with_err ? 16'($urandom) : 16'd0;
    op_ek = with_err ? 16'($urandom) : 16'd0;
    op_el = with_err ? 16'($urandom) : 16'd0;
    if (with_err && !model_err()) op_ei = 16'd1;
    op_rec = 1'($urandom);
  endtask

  task automatic apply_ops();
    bus.a = op_a; bus.b = op_b; bus.c = op_c; bus.d = op_d;
    bus.ei = op_ei; bus.ej = op_ej; bus.ek = op_ek; bus.el = op_el;
    bus.rec_en = op_rec;
  endtask

  // Count edges until out_valid is seen (capped)
  task automatic wait_out(output int lat);
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  // Present one operand set for a single edge (DUT must be idle), then wait
  task automatic do_txn(output int lat);
    apply_ops();
    pend_err = model_err();
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    wait_out(lat);
  endtask

  task automatic release_out();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    if (pend_err && exp_cnt != 16'hFFFF) exp_cnt++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    exp_cnt = 16'd0;
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    n_cmp++; if (bus.product !== 32'd0) begin n_fail++; $display("FAIL reset_product: got %h want 0", bus.product); end
    n_cmp++; if (bus.err_flag !== 1'b0) begin n_fail++; $display("FAIL reset_err_flag: got %b want 0", bus.err_flag); end
    n_cmp++; if (bus.err_count !== 16'd0) begin n_fail++; $display("FAIL reset_err_count: got %0d want 0", bus.err_count); end
  endtask

  task automatic test_reset_mid_fix();
    rand_ops(1'b1);
    op_rec = 1'b1;
    apply_ops();
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_cnt = 16'd0;
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL midfix_in_ready: got %b want 1", bus.in_ready); end
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL midfix_out_valid: got %b want 0", bus.out_valid); end
    n_cmp++; if (bus.err_count !== exp_cnt) begin n_fail++; $display("FAIL midfix_err_count: got %0d want %0d", bus.err_count, exp_cnt); end
    n_cmp++; if (bus.err_flag !== 1'b0) begin n_fail++; $display("FAIL midfix_err_flag: got %b want 0", bus.err_flag); end
    repeat (10) @(posedge clk);
    #1;
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL midfix_no_output: got %b want 0", bus.out_valid); end
  endtask

  task automatic test_approx();
    int lat;
    set_ops(19'd5, 19'd1, 19'd0, 19'd0, 16'd0, 16'd0, 16'd0, 16'd0, 1'b0);
    do_txn(lat);
    n_cmp++; if (lat !== 4) begin n_fail++; $display("FAIL approx_latency: got %0d want 4", lat); end
    n_cmp++; if (bus.product !== 32'd21) begin n_fail++; $display("FAIL approx_product: got %0d want 21", bus.product); end
    n_cmp++; if (bus.err_flag !== 1'b0) begin n_fail++; $display("FAIL approx_err_flag: got %b want 0", bus.err_flag); end
    release_out();
    n_cmp++; if (bus.err_count !== exp_cnt) begin n_fail++; $display("FAIL approx_err_count: got %0d want %0d", bus.err_count, exp_cnt); end
  endtask

  task automatic test_recovery();
    int lat;
    set_ops(19'd0, 19'd0, 19'd0, 19'd0, 16'd1, 16'd0, 16'd0, 16'd0, 1'b1);
    do_txn(lat);
    n_cmp++; if (lat !== 8) begin n_fail++; $display("FAIL rec_latency: got %0d want 8", lat); end
    n_cmp++; if (bus.product !== 32'd4) begin n_fail++; $display("FAIL rec_product: got %0d want 4", bus.product); end
    n_cmp++; if (bus.err_flag !== 1'b1) begin n_fail++; $display("FAIL rec_err_flag: got %b want 1", bus.err_flag); end
    n_cmp++; if (bus.err_count !== 16'd0) begin n_fail++; $display("FAIL rec_count_before: got %0d want 0", bus.err_count); end
    release_out();
    n_cmp++; if (bus.err_count !== 16'd1) begin n_fail++; $display("FAIL rec_count_after: got %0d want 1", bus.err_count); end
    op_rec = 1'b0;
    do_txn(lat);
    n_cmp++; if (lat !== 4) begin n_fail++; $display("FAIL norec_latency: got %0d want 4", lat); end
    n_cmp++; if (bus.product !== 32'd0) begin n_fail++; $display("FAIL norec_product: got %0d want 0", bus.product); end
    n_cmp++; if (bus.err_flag !== 1'b1) begin n_fail++; $display("FAIL norec_err_flag: got %b want 1", bus.err_flag); end
    release_out();
    n_cmp++; if (bus.err_count !== exp_cnt) begin n_fail++; $display("FAIL norec_err_count: got %0d want %0d", bus.err_count, exp_cnt); end
  endtask

  task automatic test_carry();
    int lat;
    set_ops(19'h7FFFF, 19'h7FFFF, 19'd0, 19'd0, 16'd0, 16'd0, 16'd0, 16'd0, 1'b0);
    do_txn(lat);
    n_cmp++; if (bus.product !== 32'h0087FFEF) begin n_fail++; $display("FAIL carry_product: got %h want 0087ffef", bus.product); end
    release_out();
    set_ops(19'h7FFFF, 19'h7FFFF, 19'h7FFFF, 19'h7FFFF,
            16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b1);
    do_txn(lat);
    n_cmp++; if (bus.product !== model_product()) begin n_fail++; $display("FAIL wrap_product: got %h want %h", bus.product, model_product()); end
    release_out();
  endtask

  task automatic test_backpressure();
    int lat;
    logic [31:0] exp1, exp2;
    logic err2;
    rand_ops(1'b1);
    op_rec = 1'b0;
    exp1 = model_product();
    do_txn(lat);
    n_cmp++; if (bus.product !== exp1) begin n_fail++; $display("FAIL bp_first_product: got %h want %h", bus.product, exp1); end
    rand_ops(1'b0);
    op_rec = 1'b1;
    exp2 = model_product();
    err2 = model_err();
    apply_ops();
    bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_cmp++; if (bus.product !== exp1 || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: product %h in_ready %b out_valid %b want %h 0 1", i, bus.product, bus.in_ready, bus.out_valid, exp1);
      end
    end
    release_out();
    n_cmp++; if (bus.err_count !== exp_cnt) begin n_fail++; $display("FAIL bp_count: got %0d want %0d", bus.err_count, exp_cnt); end
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_idle_ready: got %b want 1", bus.in_ready); end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    pend_err = err2;
    wait_out(lat);
    n_cmp++; if (lat !== 8) begin n_fail++; $display("FAIL bp_second_latency: got %0d want 8", lat); end
    n_cmp++; if (bus.product !== exp2) begin n_fail++; $display("FAIL bp_second_product: got %h want %h", bus.product, exp2); end
    release_out();
  endtask

  task automatic test_back_to_back(input bit rec);
    int times[$];
    int cyc;
    int exp_ii;
    logic [31:0] expp;
    rand_ops(1'b1);
    op_rec = rec;
    exp_ii = rec ? 10 : 6;
    expp = model_product();
    apply_ops();
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    cyc = 0;
    while (times.size() < 3 && cyc < 100) begin
      @(posedge clk); #1; cyc++;
      if (bus.out_valid === 1'b1) begin
        times.push_back(cyc);
        n_cmp++; if (bus.product !== expp) begin n_fail++; $display("FAIL b2b_product: got %h want %h", bus.product, expp); end
        if (times.size() == 3) bus.in_valid = 1'b0;
      end
    end
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    for (int i = 0; i < times.size(); i++)
      if (exp_cnt != 16'hFFFF) exp_cnt++;
    n_cmp++; if (times.size() != 3 || times[1] - times[0] != exp_ii || times[2] - times[1] != exp_ii) begin
      n_fail++;
      $display("FAIL b2b_interval: got %0d completions spaced %0d,%0d want 3 spaced %0d", times.size(), times[1] - times[0], times[2] - times[1], exp_ii);
    end
    n_cmp++; if (bus.err_count !== exp_cnt) begin n_fail++; $display("FAIL b2b_err_count: got %0d want %0d", bus.err_count, exp_cnt); end
    n_cmp++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain: in_ready %b out_valid %b want 1 0", bus.in_ready, bus.out_valid); end
  endtask

  task automatic test_random();
    int lat;
    int stall;
    logic [31:0] expp;
    logic expe;
    for (int t = 0; t < 25; t++) begin
      rand_ops(1'($urandom));
      expp = model_product();
      expe = model_err();
      do_txn(lat);
      n_cmp++; if (lat !== (op_rec ? 8 : 4)) begin n_fail++; $display("FAIL rand_latency[%0d]: got %0d want %0d", t, lat, op_rec ? 8 : 4); end
      n_cmp++; if (bus.product !== expp) begin n_fail++; $display("FAIL rand_product[%0d]: got %h want %h", t, bus.product, expp); end
      n_cmp++; if (bus.err_flag !== expe) begin n_fail++; $display("FAIL rand_err_flag[%0d]: got %b want %b", t, bus.err_flag, expe); end
      stall = int'($urandom_range(0, 3));
      repeat (stall) @(posedge clk);
      #1;
      n_cmp++; if (bus.product !== expp || bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL rand_stall[%0d]: product %h out_valid %b want %h 1", t, bus.product, bus.out_valid, expp); end
      release_out();
      n_cmp++; if (bus.err_count !== exp_cnt) begin n_fail++; $display("FAIL rand_err_count[%0d]: got %0d want %0d", t, bus.err_count, exp_cnt); end
    end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    set_ops('0, '0, '0, '0, '0, '0, '0, '0, 1'b0);
    apply_ops();
    pend_err = 1'b0;
    exp_cnt  = 16'd0;
    test_reset();
    test_reset_mid_fix();
    test_approx();
    test_recovery();
    test_carry();
    test_backpressure();
    test_back_to_back(1'b0);
    test_back_to_back(1'b1);
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/layer3_accumulator.md
# layer3_accumulator

Sequential final-reduction stage that sits directly downstream of the layer-2 approximate compressor array. It captures the four layer-2 partial sums and four error vectors, accumulates them into one 32-bit product over several cycles, and can optionally add the error terms back in (error recovery). A valid/ready handshake sits on each side. A saturating counter records how many products had non-zero error.

## Interface
- No parameters; widths are fixed by the 16x16 multiplier.
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand set present
- in_ready  out  1  block can accept an operand set
- rec_en  in  1  error recovery enable; sampled with operands
- a  in  [19:1]  layer-2 sum 0
- b  in  [23:5]  layer-2 sum 1
- c  in  [27:9]  layer-2 sum 2
- d  in  [31:13]  layer-2 sum 3
- ei  in  [18:3]  error vector 0
- ej  in  [22:7]  error vector 1
- ek  in  [26:11]  error vector 2
- el  in  [30:15]  error vector 3
- out_valid  out  1  product valid
- out_ready  in  1  consumer accepts product
- product  out  [32:1]  final product; bit k has weight 2^(k-1)
- err_flag  out  1  OR of all captured error bits; valid with out_valid
- err_count  out  16  number of completed products with err_flag=1; saturating

## Operation
- Weighting: every vector bit at index k has weight 2^(k-1). Numeric contributions are:
  - a, b, c, d: raw value, raw<<4, raw<<8, raw<<12.
  - ei, ej, ek, el: raw<<2, raw<<6, raw<<10, raw<<14.
- Arithmetic:
  - Accumulator is 32 bits.
  - All additions are modulo 2^32; no overflow flag.
- FSM states: IDLE, SUM, FIX, DONE.
- IDLE: in_ready=1.
  - On in_valid, all operands and rec_en are captured.
  - acc<=0, idx<=0, and the next state is SUM.
- SUM: one aligned operand is added per cycle, in the order a, b, c, d (idx 0..3).
  - After the idx=3 add, the FSM goes to FIX if the captured rec_en=1, else to DONE.
  - idx is reset to 0 on that transition.
- FIX: one aligned error vector is added per cycle, in the order ei, ej, ek, el.
  - After the idx=3 add, the FSM goes to DONE.
- DONE: out_valid=1 and product=acc.
  - On out_ready, the next state is IDLE.
  - On that same edge, err_count increments if err_flag=1, saturating at 16'hFFFF.
- in_ready is 0 in every state except IDLE. in_valid outside IDLE is ignored.
- err_flag is computed from the captured error vectors regardless of rec_en.
- err_flag and product are held stable while in DONE.
- Reset values:
  - state=IDLE, in_ready=1, out_valid=0.
  - product=0, err_flag=0, err_count=0.
  - acc=0, idx=0, all capture registers=0.
- Reset in any state, including mid-SUM/FIX or DONE with out_valid high, aborts the transaction.
  - There is no output for the aborted transaction, and err_count is not incremented for it.

## Timing
- Acceptance edge T: in_valid & in_ready.
- Without recovery: out_valid is first high in the cycle after edge T+4 (4 add cycles).
- With recovery: out_valid is first high in the cycle after edge T+8.
- Minimum initiation interval, with out_ready tied high: 6 cycles without recovery, 10 with recovery.
  - DONE→IDLE costs one edge; IDLE accepts on the next edge.
- Backpressure: DONE may be held indefinitely. Outputs stay stable and no new input is accepted.
- All outputs are registered or decoded from state; there is no combinational path from in_valid to out_valid.

## Structure
- Shared package layer3_pkg holds:
  - the state enum (IDLE, SUM, FIX, DONE);
  - localparams for operand shifts (0,4,8,12) and error shifts (2,6,10,14);
  - PROD_W=32 and CNT_W=16.
- Single module. The operand-alignment mux is indexed by idx and by the SUM/FIX phase and is inlined; no sub-module is warranted.

## Test plan
- Reset: assert rst 2 cycles → in_ready=1, out_valid=0, product=0, err_flag=0, err_count=0.
- Approximate mode: a=5, b=1, others 0, rec_en=0 → product=21, err_flag=0, out_valid exactly 4 cycles after acceptance.
- Recovery: ei=1 (bit 3), others 0, rec_en=1 → product=4, err_flag=1, err_count 0→1 after out_ready, latency 8.
  - Same stimulus with rec_en=0 → product=0, err_flag=1.
- Width/carry: a=19'h7FFFF, b=19'h7FFFF, others 0, rec_en=0 → product=32'h0087FFEF.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while in_valid=1 with new data → product unchanged, in_ready=0; second transaction is accepted only after out_ready, and its result is correct.
- Reset mid-FIX: rst during the 2nd FIX cycle → next cycle IDLE, in_ready=1, out_valid=0, err_count unchanged from before (0).
